cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Owns the instruction register (IR) and the M-cycle step counter that drive the opcode decoder.
//  Each cycle it presents {opcode, step} to the decoder and consumes done / is_cond / next_cond.
//  From these it fetches the next opcode, evaluates branch conditions against the flags,
//  and handles bus stalls, HALT and illegal opcodes.
//  Sits between the register file / memory bus and the decoder in the CPU core.
// PARAMETERS
//  STEP_W      3      step counter width; must match the decoder step input
//  HALT_OPC    8'h76  opcode treated as HALT (pre-empts the decoder's LD (HL),r decode)
//  RESET_OPC   8'h00  IR value while in BOOT (ignored by datapath; boot_fetch governs)
// PORTS
//  clk         in   1       core clock
//  reset       in   1       synchronous, active-high
//  stall       in   1       bus not ready; freezes all sequencer state this cycle
//  db_in       in   8       data bus read value (opcode byte on fetch cycles)
//  flag_z      in   1       Z flag from register file
//  flag_c      in   1       C flag from register file
//  wake        in   1       level; leaves HALT when high
//  dc_done     in   1       decoder: last M-cycle of opcode
//  dc_is_cond  in   1       decoder: branch on cc this cycle
//  dc_next     in   STEP_W  decoder: step to take if cc is false
//  opcode      out  8       IR, to decoder
//  step        out  STEP_W  current step, to decoder
//  boot_fetch  out  1       datapath forces s_ab=PC, inc PC, wr_pc=1 this cycle
//  halted      out  1       core is in HALT; datapath issues no writes
//  illegal     out  1       sticky; opcode ran past the last step without done
// BEHAVIOUR
//  States (in cpu_pkg): BOOT, EXEC, HALT, LOCK.
//  Reset:
//   - state=BOOT, opcode=RESET_OPC, step=0, boot_fetch=1, halted=0, illegal=0.
//   - Reset mid-instruction abandons it with no further side effects.
//  Stall:
//   - When stall=1, state, IR and step hold.
//   - Outputs stay stable and are a function of the held state.
//   - Stall has priority over every transition below except reset.
//  BOOT: boot_fetch=1. Next edge: opcode<=db_in, step<=0, state<=EXEC. Latency is 1 cycle.
//  EXEC, evaluated in priority order:
//   1. dc_done=1: opcode<=db_in (overlapped fetch); step<=0.
//      If db_in==HALT_OPC, state<=HALT; otherwise stay in EXEC.
//   2. dc_is_cond=1: compute cc_true from opcode[4:3] (00 NZ, 01 Z, 10 NC, 11 C).
//      step <= cc_true ? step+1 : dc_next.
//   3. Otherwise step<=step+1.
//   4. If step is at its maximum (2^STEP_W - 1) with dc_done=0: state<=LOCK, illegal<=1.
//      Step does not wrap to 0.
//   - dc_done together with dc_is_cond: done wins.
//  HALT:
//   - halted=1; opcode holds HALT_OPC and step=0.
//   - The decoder outputs are ignored by the datapath because halted=1 gates all writes.
//   - wake=1 at an edge: state<=BOOT, so the next cycle refetches at PC.
//   - wake already high on HALT entry: leave after exactly one HALT cycle.
//  LOCK:
//   - halted=1, illegal=1; IR and step hold. Only reset exits.
//  flags are sampled in the same cycle dc_is_cond is asserted.
//  The datapath must not write flags in a cycle where is_cond=1.
//  All outputs are registered except boot_fetch and halted, which decode the current state (no input paths).
// STRUCTURE
//  cpu_pkg carries:
//   - seq_state_t {BOOT, EXEC, HALT, LOCK}
//   - cc_t {CC_NZ, CC_Z, CC_NC, CC_C}
//   - HALT_OPC constant
//   - opcode_t, shared with the decoder
//  Sub-module cc_eval (combinational: cc_t, flag_z, flag_c -> cc_true).
//  All else is a single always_ff plus a small next-state always_comb.
// TESTING
//  1. Reset boot:
//     - reset for 2 cycles, then db_in=8'h3E.
//     - Required: boot_fetch=1 in the first cycle after reset, then opcode=8'h3E, step=0.
//  2. Multi-step op:
//     - dc_done low for steps 0 and 1, high at step 2, db_in=8'h00 on that cycle.
//     - Required: step follows 0,1,2,0 and opcode becomes 8'h00.
//  3. Conditional jump:
//     - opcode=8'h28 (JR Z), step 0, dc_is_cond=1, dc_next=3.
//     - flag_z=0 -> step 3; flag_z=1 -> step 1.
//  4. Stall:
//     - stall=1 for 3 cycles at step 1 with dc_done=1.
//     - Required: step=1 and opcode unchanged for all 3 cycles; the transition happens on the first unstalled edge.
//  5. HALT:
//     - done with db_in=8'h76 -> halted=1.
//     - Hold for 5 cycles, then wake=1 -> BOOT next cycle, boot_fetch=1, halted=0.
//  6. Runaway:
//     - dc_done never asserted.
//     - Required: step reaches 7, then illegal=1 and halted=1 are sticky.
//     - A subsequent reset clears both.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_pkg : shared types and constants for the sequencer and the decoder.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cpu_pkg;

  typedef logic [7:0] opcode_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2,
    LOCK = 2'd3
  } seq_state_t;

  // Encoding matches opcode bits [4:3] of the conditional branch group.
  typedef enum logic [1:0] {
    CC_NZ = 2'd0,
    CC_Z  = 2'd1,
    CC_NC = 2'd2,
    CC_C  = 2'd3
  } cc_t;

  localparam opcode_t HALT_OPC  = 8'h76;
  localparam opcode_t RESET_OPC = 8'h00;

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_sequencer_if : bus/decoder signals between core and sequencer.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cpu_sequencer_if #(
  parameter int STEP_W = 3
);
  import cpu_pkg::*;

  logic              stall;
  opcode_t           db_in;
  logic              flag_z;
  logic              flag_c;
  logic              wake;
  logic              dc_done;
  logic              dc_is_cond;
  logic [STEP_W-1:0] dc_next;

  opcode_t           opcode;
  logic [STEP_W-1:0] step;
  logic              boot_fetch;
  logic              halted;
  logic              illegal;

  // Core side: bus, flags and decoder feed the sequencer.
  modport master (
    output stall, db_in, flag_z, flag_c, wake, dc_done, dc_is_cond, dc_next,
    input  opcode, step, boot_fetch, halted, illegal
  );

  modport slave (
    input  stall, db_in, flag_z, flag_c, wake, dc_done, dc_is_cond, dc_next,
    output opcode, step, boot_fetch, halted, illegal
  );

endinterface
`default_nettype wire

// File: rtl/cc_eval.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cc_eval : combinational branch-condition evaluator (cc, Z, C -> true).   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cc_eval
  import cpu_pkg::*;
(
  input  cc_t  i_cc,
  input  logic i_flag_z,
  input  logic i_flag_c,
  output logic o_cc_true
);

  always_comb begin
    o_cc_true = 1'b0;
    unique case (i_cc)
      CC_NZ: o_cc_true = ~i_flag_z;
      CC_Z:  o_cc_true =  i_flag_z;
      CC_NC: o_cc_true = ~i_flag_c;
      CC_C:  o_cc_true =  i_flag_c;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_sequencer : IR and M-cycle step counter feeding the opcode decoder.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int      STEP_W    = 3,
  parameter opcode_t HALT_OPC  = cpu_pkg::HALT_OPC,
  parameter opcode_t RESET_OPC = cpu_pkg::RESET_OPC
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.slave  bus
);

  localparam logic [STEP_W-1:0] STEP_ZERO = '0;
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_MAX  = '1;

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  opcode_t           r_opcode;
  opcode_t           w_opcode_nxt;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;
  logic              r_illegal;
  logic              w_illegal_nxt;
  cc_t               w_cc;
  logic              w_cc_true;

  assign w_cc = cc_t'(r_opcode[4:3]);

  cc_eval u_cc_eval (
    .i_cc      (w_cc),
    .i_flag_z  (bus.flag_z),
    .i_flag_c  (bus.flag_c),
    .o_cc_true (w_cc_true)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_opcode_nxt  = r_opcode;
    w_step_nxt    = r_step;
    w_illegal_nxt = r_illegal;

    if (!bus.stall) begin
      unique case (r_state)
        BOOT: begin
          w_opcode_nxt = bus.db_in;
          w_step_nxt   = STEP_ZERO;
          w_state_nxt  = EXEC;
        end
        EXEC: begin
          if (bus.dc_done) begin
            // Overlapped fetch: the next opcode is on the bus in the last M-cycle.
            w_opcode_nxt = bus.db_in;
            w_step_nxt   = STEP_ZERO;
            if (bus.db_in == HALT_OPC) begin
              w_state_nxt = HALT;
            end
          end else if (r_step == STEP_MAX) begin
            w_state_nxt   = LOCK;
            w_illegal_nxt = 1'b1;
          end else if (bus.dc_is_cond) begin
            w_step_nxt = w_cc_true ? (r_step + STEP_ONE) : bus.dc_next;
          end else begin
            w_step_nxt = r_step + STEP_ONE;
          end
        end
        HALT: begin
          if (bus.wake) begin
            w_state_nxt  = BOOT;
            w_opcode_nxt = RESET_OPC;
            w_step_nxt   = STEP_ZERO;
          end
        end
        LOCK: begin
          w_state_nxt = LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= BOOT;
      r_opcode  <= RESET_OPC;
      r_step    <= STEP_ZERO;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_opcode  <= w_opcode_nxt;
      r_step    <= w_step_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign bus.opcode     = r_opcode;
  assign bus.step       = r_step;
  assign bus.illegal    = r_illegal;
  assign bus.boot_fetch = (r_state == BOOT);
  assign bus.halted     = (r_state == HALT) || (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_sequencer : vector table and scoreboard bench for cpu_sequencer.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int STEP_W = 3;

  typedef struct {
    logic       stall;
    logic [7:0] db;
    logic       fz;
    logic       fc;
    logic       wake;
    logic       done;
    logic       cond;
    logic [2:0] nxt;
    logic [7:0] e_op;
    logic [2:0] e_step;
    logic       e_boot;
    logic       e_halt;
    logic       e_ill;
  } vec_t;

  typedef struct {
    string       name;
    logic [13:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_sequencer_if #(.STEP_W(STEP_W)) bus ();

  cpu_sequencer #(
    .STEP_W    (STEP_W),
    .HALT_OPC  (8'h76),
    .RESET_OPC (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic vec_t mk(
    input logic stall, input logic [7:0] db, input logic fz, input logic fc,
    input logic wake, input logic done, input logic cond, input logic [2:0] nxt,
    input logic [7:0] e_op, input logic [2:0] e_step, input logic e_boot,
    input logic e_halt, input logic e_ill);
    vec_t v;
    v.stall = stall; v.db = db; v.fz = fz; v.fc = fc; v.wake = wake;
    v.done = done; v.cond = cond; v.nxt = nxt;
    v.e_op = e_op; v.e_step = e_step; v.e_boot = e_boot;
    v.e_halt = e_halt; v.e_ill = e_ill;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expected result, then compare after the edge.
  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    logic [13:0] act;
    bus.stall      = v.stall;
    bus.db_in      = v.db;
    bus.flag_z     = v.fz;
    bus.flag_c     = v.fc;
    bus.wake       = v.wake;
    bus.dc_done    = v.done;
    bus.dc_is_cond = v.cond;
    bus.dc_next    = v.nxt;
    sb.push_back('{nm, {v.e_op, v.e_step, v.e_boot, v.e_halt, v.e_ill}});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    act = {bus.opcode, bus.step, bus.boot_fetch, bus.halted, bus.illegal};
    checks++;
    if (act !== e.val) begin
      errors++;
      $display("FAIL %s: got op=%h step=%0d boot=%b halt=%b ill=%b, want op=%h step=%0d boot=%b halt=%b ill=%b",
               e.name, act[13:6], act[5:3], act[2], act[1], act[0],
               e.val[13:6], e.val[5:3], e.val[2], e.val[1], e.val[0]);
    end
  endtask

  initial begin
    // Reset for two cycles: BOOT state, IR = RESET_OPC.
    reset = 1'b1;
    run_vec(mk(0, 8'h3E, 0, 0, 0, 0, 0, 3'd0, 8'h00, 3'd0, 1, 0, 0), "reset_c1");
    run_vec(mk(0, 8'h3E, 0, 0, 0, 0, 0, 3'd0, 8'h00, 3'd0, 1, 0, 0), "reset_c2");
    reset = 1'b0;

    //       stall db    fz fc wk dn cd nxt  e_op   st  bt ht il
    tbl.push_back(mk(1, 8'h3E, 0, 0, 0, 0, 0, 3'd0, 8'h00, 3'd0, 1, 0, 0)); // stall in BOOT
    tbl.push_back(mk(0, 8'h3E, 0, 0, 0, 0, 0, 3'd0, 8'h3E, 3'd0, 0, 0, 0)); // boot fetch
    tbl.push_back(mk(0, 8'h11, 0, 0, 0, 0, 0, 3'd0, 8'h3E, 3'd1, 0, 0, 0)); // multi-step
    tbl.push_back(mk(0, 8'h11, 0, 0, 0, 0, 0, 3'd0, 8'h3E, 3'd2, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 3'd0, 8'h00, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h28, 0, 0, 0, 1, 0, 3'd0, 8'h28, 3'd0, 0, 0, 0)); // JR Z
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 3'd3, 8'h28, 3'd3, 0, 0, 0)); // Z=0 -> next
    tbl.push_back(mk(0, 8'h28, 0, 0, 0, 1, 0, 3'd0, 8'h28, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 3'd3, 8'h28, 3'd1, 0, 0, 0)); // Z=1 -> +1
    tbl.push_back(mk(1, 8'h3E, 0, 0, 0, 1, 0, 3'd0, 8'h28, 3'd1, 0, 0, 0)); // stall x3
    tbl.push_back(mk(1, 8'h3E, 0, 0, 0, 1, 0, 3'd0, 8'h28, 3'd1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h3E, 0, 0, 0, 1, 0, 3'd0, 8'h28, 3'd1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h3E, 0, 0, 0, 1, 0, 3'd0, 8'h3E, 3'd0, 0, 0, 0)); // unstalled
    tbl.push_back(mk(0, 8'h38, 0, 0, 0, 1, 1, 3'd5, 8'h38, 3'd0, 0, 0, 0)); // done beats cond
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 3'd5, 8'h38, 3'd5, 0, 0, 0)); // C, C=0 -> next
    tbl.push_back(mk(0, 8'h30, 0, 0, 0, 1, 0, 3'd0, 8'h30, 3'd0, 0, 0, 0)); // NC
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 3'd4, 8'h30, 3'd1, 0, 0, 0)); // C=0 -> +1
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 3'd4, 8'h30, 3'd4, 0, 0, 0)); // C=1 -> next
    tbl.push_back(mk(0, 8'h20, 0, 0, 0, 1, 0, 3'd0, 8'h20, 3'd0, 0, 0, 0)); // NZ
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 3'd6, 8'h20, 3'd1, 0, 0, 0)); // Z=0 -> +1
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 3'd6, 8'h20, 3'd6, 0, 0, 0)); // Z=1 -> next
    tbl.push_back(mk(0, 8'h76, 0, 0, 0, 1, 0, 3'd0, 8'h76, 3'd0, 0, 1, 0)); // enter HALT
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 8'h3E, 1, 1, 0, 1, 1, 3'd2, 8'h76, 3'd0, 0, 1, 0)); // hold 5
    tbl.push_back(mk(0, 8'h3E, 0, 0, 1, 0, 0, 3'd0, 8'h00, 3'd0, 1, 0, 0)); // wake -> BOOT
    tbl.push_back(mk(0, 8'h3E, 0, 0, 0, 0, 0, 3'd0, 8'h3E, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h76, 0, 0, 1, 1, 0, 3'd0, 8'h76, 3'd0, 0, 1, 0)); // wake held
    tbl.push_back(mk(0, 8'h3E, 0, 0, 1, 0, 0, 3'd0, 8'h00, 3'd0, 1, 0, 0)); // one HALT cycle
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 0, 0, 3'd0, 8'h01, 3'd0, 0, 0, 0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Runaway: dc_done never asserted, step climbs to 7 then locks.
    for (int s = 1; s <= 7; s++)
      run_vec(mk(0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 8'h01, 3'(s), 0, 0, 0), $sformatf("run_step%0d", s));
    run_vec(mk(0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 8'h01, 3'd7, 0, 1, 1), "lock_entry");
    for (int i = 0; i < 3; i++)
      run_vec(mk(0, 8'h3E, 0, 0, 1, 1, 1, 3'd2, 8'h01, 3'd7, 0, 1, 1), $sformatf("lock_sticky%0d", i));
    reset = 1'b1;
    run_vec(mk(0, 8'h3E, 0, 0, 0, 0, 0, 3'd0, 8'h00, 3'd0, 1, 0, 0), "lock_reset");
    reset = 1'b0;

    // Reset in the middle of a multi-step instruction abandons it.
    run_vec(mk(0, 8'h3E, 0, 0, 0, 0, 0, 3'd0, 8'h3E, 3'd0, 0, 0, 0), "mid_boot");
    run_vec(mk(0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 8'h3E, 3'd1, 0, 0, 0), "mid_step1");
    reset = 1'b1;
    run_vec(mk(0, 8'h76, 0, 0, 0, 1, 0, 3'd0, 8'h00, 3'd0, 1, 0, 0), "mid_reset");
    reset = 1'b0;
    run_vec(mk(0, 8'h22, 0, 0, 0, 0, 0, 3'd0, 8'h22, 3'd0, 0, 0, 0), "mid_reboot");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
